// File: rtl/mesm6_pkg.sv
// Shared types for the main-RAM arbiter: memory geometry, arbiter states, requester ids.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the arbiter and its testbench.
package mesm6_pkg;

    localparam int MEM_AW = 15;
    localparam int MEM_DW = 48;

    typedef logic [MEM_DW-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the main RAM between instruction fetch (I) and load/store (D).
// Latency: req sampled at edge k, RAM strobe after k+1, ack after k+3; one access per 4 cycles.
// Requests are level-held until ack; a stalled RAM is cut off by the TIMEOUT watchdog with bus_err.
module memory_arbiter
    import mesm6_pkg::*;
#(
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          bus_err,
    output logic [AW-1:0] m_addr,
    output logic          m_read,
    output logic          m_write,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_done
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    arb_state_t state_q, state_nxt;
    port_t      grant_q, last_q, sel;
    logic       sel_vld, i_cand, d_cand;
    logic       we_q, to_q;
    logic [7:0] cnt_q, cnt_inc;

    // A port still showing its ack has just been served; its held req is stale.
    always_comb begin
        state_nxt = state_q;
        sel       = PORT_I;
        i_cand    = i_req && !i_ack;
        d_cand    = d_req && !d_ack;
        sel_vld   = i_cand || d_cand;
        cnt_inc   = cnt_q + 8'd1;

        if (i_cand && d_cand) begin
            sel = (last_q == PORT_D) ? PORT_I : PORT_D;
        end else if (d_cand) begin
            sel = PORT_D;
        end

        case (state_q)
            IDLE:    if (sel_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (m_done || cnt_inc == TO_LIMIT) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= PORT_I;
            last_q  <= PORT_D;
            we_q    <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state_q <= state_nxt;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        grant_q <= sel;
                        if (sel == PORT_D) begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            we_q    <= d_we;
                        end else begin
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    m_read  <= !we_q;
                    m_write <= we_q;
                    cnt_q   <= '0;
                    to_q    <= 1'b0;
                end
                WAIT: begin
                    if (m_done) begin
                        if (!we_q) begin
                            if (grant_q == PORT_D) d_rdata <= m_rdata;
                            else                   i_rdata <= m_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                        // Timed-out reads return zero; a timed-out write leaves d_rdata alone.
                        if (cnt_inc == TO_LIMIT) begin
                            to_q <= 1'b1;
                            if (!we_q) begin
                                if (grant_q == PORT_D) d_rdata <= '0;
                                else                   i_rdata <= '0;
                            end
                        end
                    end
                end
                RESP: begin
                    if (grant_q == PORT_D) d_ack <= 1'b1;
                    else                   i_ack <= 1'b1;
                    bus_err <= to_q;
                    last_q  <= grant_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sequences and shares the 32K x 48-bit main RAM between two requesters: instruction fetch (port I) and operand load/store (port D) of the control unit.
- Converts each requester's level-held request into the single-cycle read/write strobe the RAM expects; waits for the RAM's done flag; returns data with a one-cycle acknowledge.
- Adds round-robin arbitration and a bus-timeout watchdog.

Parameters:
- AW, 15, word address width
- DW, 48, data word width
- TIMEOUT, 15, max cycles in WAIT before error termination (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction-port request, held until i_ack
- i_addr  in  AW  instruction address (read only)
- i_ack  out  1  one-cycle acknowledge; i_rdata valid in same cycle
- i_rdata  out  DW  fetched word
- d_req  in  1  data-port request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle acknowledge
- d_rdata  out  DW  loaded word (valid with d_ack on reads)
- bus_err  out  1  pulses with the ack when the access timed out
- m_addr  out  AW  to RAM address input
- m_read  out  1  to RAM read strobe
- m_write  out  1  to RAM write strobe
- m_wdata  out  DW  to RAM write data
- m_rdata  in  DW  from RAM data output
- m_done  in  1  from RAM done flag

Behaviour:
- All outputs registered. Reset values: every ack, strobe, bus_err and m_addr/m_wdata/rdata = 0; state IDLE; last-grant = D, so I wins first conflict.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Sample i_req/d_req at the clock edge.
  - If one is high, grant it. If both are high, grant the port not granted last.
  - Latch address, we and wdata into m_* and go to ISSUE.
  - A port whose ack is high in that cycle is ignored (its req is still high from the finished transfer).
- ISSUE: exactly one cycle. m_read = !we or m_write = we is asserted for this cycle only, never both, never longer. Next state WAIT; timeout counter cleared.
- WAIT:
  - On m_done = 1: capture m_rdata into the granted port's rdata and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT, go to RESP with bus_err and rdata = 0.
- RESP: granted port's ack = 1 (plus bus_err if timed out) for one cycle; update last-grant; next state IDLE.
- Latency with the standard RAM: req high at edge k -> strobe high after edge k+1 -> m_done seen at edge k+2 -> ack high after edge k+3 for one cycle. Throughput: one access per 4 cycles; back-to-back access to the other port starts with no extra bubble.
- The non-granted port's rdata holds its previous value. Request inputs are ignored outside IDLE. Address/data changes on a held request have no effect after the grant.
- Writes: d_rdata unchanged; d_ack still issued.
- m_done outside WAIT is ignored.
- Reset mid-operation: return to IDLE next edge, strobes dropped, pending ack discarded. The requester must reissue.
- Fairness: with both reqs held permanently, grants alternate I, D, I, D.

Decomposition:
- Shared package mesm6_pkg: AW/DW constants, word typedef, arbiter state enum (IDLE, ISSUE, WAIT, RESP), port-select enum (PORT_I, PORT_D).
- No sub-module needed. Grant selection is a small always_comb block inside the arbiter; the watchdog is an inline counter.

Test Plan:
- Reset then i_req, addr 0o00001, RAM word 1 preloaded to 0o2240000031000002 -> m_read is a single-cycle pulse with m_addr=1; i_ack pulses 3 cycles after the request edge with i_rdata=0o2240000031000002; m_write never high.
- d_req write addr 0o00100, data 0o7777777777777777, then d_req read of the same address -> one m_write pulse; d_rdata=0o7777777777777777 on the second d_ack; i_ack stays 0.
- i_req and d_req asserted together, held for 4 transfers -> grant order I, D, I, D; never two strobes in one cycle.
- m_done tied 0, TIMEOUT=15 -> ack plus bus_err pulse exactly 15 cycles after entering WAIT; rdata=0; arbiter returns to IDLE and serves the next request normally.
- reset asserted during WAIT of a d read -> no d_ack, strobes 0 the cycle after reset, state IDLE; after release, a held d_req is re-granted.
- i_req held after its ack while d_req idle -> second fetch starts only after the ack cycle, so exactly one access is issued per ack, with no duplicate m_read.
